// File: rtl/simon_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : simon_sequencer                                            |
// | Description : Player-side controller for a Simon memory game. Cleans up  |
// |               raw buttons, sequences game start / play / game over,      |
// |               forwards accepted player presses to the engine, drives the |
// |               colour lamps and keeps the current and best score.         |
// | Ports       : clk           - system clock (rising edge)                 |
// |               reset         - asynchronous active-low reset              |
// |               btn[3:0]      - raw colour buttons, active-high            |
// |               start         - raw start button, active-high              |
// |               simonTurn     - 1 = engine presenting, 0 = player turn     |
// |               simonNum[1:0] - colour the engine is presenting            |
// |               simonPressed  - engine colour-lit flag                     |
// |               gameOver      - engine game-over flag                      |
// |               simonRst      - active-high reset to the engine            |
// |               playerNum     - encoded accepted player colour             |
// |               playerPressed - one-cycle strobe qualifying playerNum      |
// |               led[3:0]      - colour lamps                               |
// |               score, best   - current / best rounds cleared              |
// |               phase         - 0 IDLE, 1 CLEAR, 2 PLAY, 3 OVER            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module simon_sequencer #(
  parameter int DEBOUNCE   = 3,
  parameter int BLINK      = 30,
  parameter int CLR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       start,
  input  logic       simonTurn,
  input  logic [1:0] simonNum,
  input  logic       simonPressed,
  input  logic       gameOver,
  output logic       simonRst,
  output logic [1:0] playerNum,
  output logic       playerPressed,
  output logic [3:0] led,
  output logic [3:0] score,
  output logic [3:0] best,
  output logic [1:0] phase
);

  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int BL_W  = $clog2(BLINK + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t state;

  // Bit 4 is start, bits 3:0 are the colour buttons.
  logic [4:0] raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] deb_cur;
  logic [4:0] deb_next;

  assign raw = {start, btn};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-bit debouncer. deb_next is the level the debouncer will hold after
  // this edge, so the controller can react in the same edge the debounced
  // level changes (zero added latency, outputs still registered).
  for (genvar i = 0; i < 5; i++) begin : g_debounce
    logic [DB_W-1:0] cnt;
    logic            level;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync2[i] == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt   <= '0;
        level <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb_cur[i]  = level;
    assign deb_next[i] = ((sync2[i] != level) && (cnt == DB_LAST)) ? sync2[i] : level;
  end

  logic [3:0] btn_cur;
  logic [3:0] btn_next;
  logic       start_edge;
  logic       press_edge;
  logic       turn_prev;
  logic       turn_rise;
  logic       held;
  logic [1:0] low_idx;
  logic [BL_W-1:0]  blink_cnt;
  logic [CLR_W-1:0] clr_cnt;

  assign btn_cur    = deb_cur[3:0];
  assign btn_next   = deb_next[3:0];
  assign start_edge = deb_next[4] & ~deb_cur[4];
  // All-zero to non-zero only: simultaneous buttons give one edge, and a
  // button already held when the player turn begins never forms an edge.
  assign press_edge = (btn_cur == 4'b0000) && (btn_next != 4'b0000);
  assign turn_rise  = simonTurn & ~turn_prev;

  always_comb begin
    low_idx = 2'd0;
    if (btn_next[0])      low_idx = 2'd0;
    else if (btn_next[1]) low_idx = 2'd1;
    else if (btn_next[2]) low_idx = 2'd2;
    else if (btn_next[3]) low_idx = 2'd3;
  end

  function automatic logic [3:0] one_hot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign phase = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      simonRst      <= 1'b0;
      playerNum     <= 2'd0;
      playerPressed <= 1'b0;
      led           <= 4'b0000;
      score         <= 4'd0;
      best          <= 4'd0;
      turn_prev     <= 1'b0;
      held          <= 1'b0;
      blink_cnt     <= '0;
      clr_cnt       <= '0;
    end else begin
      turn_prev     <= simonTurn;
      playerPressed <= 1'b0;
      case (state)
        ST_IDLE: begin
          led      <= 4'b0000;
          simonRst <= 1'b0;
          held     <= 1'b0;
          if (start_edge) begin
            state    <= ST_CLEAR;
            simonRst <= 1'b1;
            clr_cnt  <= '0;
            score    <= 4'd0;
          end
        end

        ST_CLEAR: begin
          led   <= 4'b0000;
          score <= 4'd0;
          held  <= 1'b0;
          if (clr_cnt == CLR_LAST) begin
            state    <= ST_PLAY;
            simonRst <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        ST_PLAY: begin
          if (gameOver) begin
            // Game over wins over any press arriving on the same edge.
            state     <= ST_OVER;
            led       <= 4'b1111;
            blink_cnt <= '0;
            held      <= 1'b0;
            if (score > best) best <= score;
          end else begin
            if (turn_rise && (score != 4'd15)) score <= score + 1'b1;
            if (simonTurn) begin
              held <= 1'b0;
              led  <= simonPressed ? one_hot(simonNum) : 4'b0000;
            end else if (press_edge) begin
              playerNum     <= low_idx;
              playerPressed <= 1'b1;
              held          <= 1'b1;
              led           <= one_hot(low_idx);
            end else if (held && btn_next[playerNum]) begin
              led <= one_hot(playerNum);
            end else begin
              held <= 1'b0;
              led  <= 4'b0000;
            end
          end
        end

        ST_OVER: begin
          if (start_edge) begin
            state    <= ST_CLEAR;
            simonRst <= 1'b1;
            clr_cnt  <= '0;
            score    <= 4'd0;
            led      <= 4'b0000;
          end else if (blink_cnt == BL_LAST) begin
            led       <= ~led;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simon_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_simon_sequencer                                         |
// | Description : Directed self-checking bench for simon_sequencer.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_simon_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       start;
  logic       simonTurn;
  logic [1:0] simonNum;
  logic       simonPressed;
  logic       gameOver;
  logic       simonRst;
  logic [1:0] playerNum;
  logic       playerPressed;
  logic [3:0] led;
  logic [3:0] score;
  logic [3:0] best;
  logic [1:0] phase;

  int checks   = 0;
  int failures = 0;

  simon_sequencer #(.DEBOUNCE(3), .BLINK(30), .CLR_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .start        (start),
    .simonTurn    (simonTurn),
    .simonNum     (simonNum),
    .simonPressed (simonPressed),
    .gameOver     (gameOver),
    .simonRst     (simonRst),
    .playerNum    (playerNum),
    .playerPressed(playerPressed),
    .led          (led),
    .score        (score),
    .best         (best),
    .phase        (phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    repeat (6) tick();
    start = 1'b0;
    repeat (6) tick();
  endtask

  task automatic turn_pulse();
    simonTurn = 1'b1;
    repeat (2) tick();
    simonTurn = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    checks++;
    if (phase !== 2'd0) begin failures++; $display("FAIL reset_phase: got %0d want 0", phase); end
    checks++;
    if ({simonRst, playerPressed, playerNum} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl: got rst=%b pp=%b pn=%0d want all 0", simonRst, playerPressed, playerNum);
    end
    checks++;
    if ({led, score, best} !== 12'h000) begin
      failures++; $display("FAIL reset_vals: got led=%b score=%0d best=%0d want 0", led, score, best);
    end
  endtask

  task automatic test_start();
    int rst_cycles;
    int first;
    logic [1:0] ph7;
    rst_cycles = 0;
    first = -1;
    ph7 = 2'd0;
    start = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 6) start = 1'b0;
      if (simonRst === 1'b1) begin
        rst_cycles++;
        if (first < 0) first = t;
      end
      if (t == 7) ph7 = phase;
    end
    checks++;
    if (rst_cycles != 2) begin failures++; $display("FAIL start_rst_len: got %0d cycles want 2", rst_cycles); end
    checks++;
    if (first != 5) begin failures++; $display("FAIL start_rst_first: got cycle %0d want 5", first); end
    checks++;
    if (ph7 !== 2'd2) begin failures++; $display("FAIL start_phase7: got %0d want 2", ph7); end
    checks++;
    if (score !== 4'd0) begin failures++; $display("FAIL start_score: got %0d want 0", score); end
  endtask

  task automatic test_single_press();
    int pulses;
    int first;
    int led_bad;
    pulses = 0;
    first = -1;
    led_bad = 0;
    btn = 4'b0100;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (playerPressed === 1'b1) begin
        pulses++;
        if (first < 0) first = t;
      end
      if (t >= 5 && led !== 4'b0100) led_bad++;
    end
    btn = 4'b0000;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (playerPressed === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL single_pulses: got %0d want 1", pulses); end
    checks++;
    if (first != 5) begin failures++; $display("FAIL single_latency: got %0d want 5", first); end
    checks++;
    if (playerNum !== 2'd2) begin failures++; $display("FAIL single_num: got %0d want 2", playerNum); end
    checks++;
    if (led_bad != 0) begin failures++; $display("FAIL single_led_held: got %0d bad cycles want 0", led_bad); end
    checks++;
    if (led !== 4'b0000) begin failures++; $display("FAIL single_led_release: got %b want 0000", led); end
  endtask

  task automatic test_simultaneous();
    int pulses;
    pulses = 0;
    btn = 4'b1010;
    repeat (8) begin tick(); if (playerPressed === 1'b1) pulses++; end
    checks++;
    if (pulses != 1 || playerNum !== 2'd1) begin
      failures++; $display("FAIL simul_first: got pulses=%0d num=%0d want 1/1", pulses, playerNum);
    end
    pulses = 0;
    btn = 4'b1000;
    repeat (8) begin tick(); if (playerPressed === 1'b1) pulses++; end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL simul_partial: got %0d pulses want 0", pulses); end
    btn = 4'b0000;
    repeat (8) begin tick(); if (playerPressed === 1'b1) pulses++; end
    btn = 4'b1000;
    repeat (8) begin tick(); if (playerPressed === 1'b1) pulses++; end
    checks++;
    if (pulses != 1 || playerNum !== 2'd3) begin
      failures++; $display("FAIL simul_repress: got pulses=%0d num=%0d want 1/3", pulses, playerNum);
    end
    btn = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    btn = 4'b0001;
    repeat (2) begin tick(); if (playerPressed === 1'b1) pulses++; end
    btn = 4'b0000;
    repeat (8) begin tick(); if (playerPressed === 1'b1) pulses++; end
    checks++;
    if (pulses != 0 || playerNum !== 2'd3) begin
      failures++; $display("FAIL glitch: got pulses=%0d num=%0d want 0/3", pulses, playerNum);
    end
  endtask

  task automatic test_start_ignored();
    int rst_seen;
    rst_seen = 0;
    start = 1'b1;
    repeat (6) begin tick(); if (simonRst === 1'b1) rst_seen++; end
    start = 1'b0;
    repeat (6) begin tick(); if (simonRst === 1'b1) rst_seen++; end
    checks++;
    if (phase !== 2'd2 || rst_seen != 0) begin
      failures++; $display("FAIL start_ignored: got phase=%0d rst=%0d want 2/0", phase, rst_seen);
    end
  endtask

  task automatic test_simon_turn();
    int pulses;
    pulses = 0;
    simonTurn = 1'b1;
    simonNum = 2'd2;
    simonPressed = 1'b1;
    repeat (2) tick();
    checks++;
    if (led !== 4'b0100) begin failures++; $display("FAIL turn_led_lit: got %b want 0100", led); end
    simonPressed = 1'b0;
    repeat (2) tick();
    checks++;
    if (led !== 4'b0000) begin failures++; $display("FAIL turn_led_dark: got %b want 0000", led); end
    simonNum = 2'd3;
    simonPressed = 1'b1;
    btn = 4'b0001;
    repeat (8) begin tick(); if (playerPressed === 1'b1) pulses++; end
    checks++;
    if (led !== 4'b1000) begin failures++; $display("FAIL turn_led_num3: got %b want 1000", led); end
    simonTurn = 1'b0;
    simonPressed = 1'b0;
    repeat (6) begin tick(); if (playerPressed === 1'b1) pulses++; end
    checks++;
    if (led !== 4'b0000) begin failures++; $display("FAIL turn_led_stale: got %b want 0000", led); end
    btn = 4'b0000;
    repeat (8) begin tick(); if (playerPressed === 1'b1) pulses++; end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL turn_no_press: got %0d pulses want 0", pulses); end
    checks++;
    if (score !== 4'd1) begin failures++; $display("FAIL turn_score: got %0d want 1", score); end
  endtask

  task automatic test_score_over();
    int bad_on;
    int bad_off;
    bad_on = 0;
    bad_off = 0;
    turn_pulse();
    turn_pulse();
    checks++;
    if (score !== 4'd3) begin failures++; $display("FAIL over_score: got %0d want 3", score); end
    gameOver = 1'b1;
    tick();
    checks++;
    if (phase !== 2'd3 || best !== 4'd3) begin
      failures++; $display("FAIL over_entry: got phase=%0d best=%0d want 3/3", phase, best);
    end
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) tick();
      if (k < 30 && led !== 4'b1111) bad_on++;
      if (k >= 30 && k < 60 && led !== 4'b0000) bad_off++;
      if (k == 60 && led !== 4'b1111) bad_on++;
    end
    checks++;
    if (bad_on != 0) begin failures++; $display("FAIL over_blink_on: got %0d bad cycles want 0", bad_on); end
    checks++;
    if (bad_off != 0) begin failures++; $display("FAIL over_blink_off: got %0d bad cycles want 0", bad_off); end
    gameOver = 1'b0;
    tick();
  endtask

  task automatic test_over_collision();
    int pulses;
    pulses = 0;
    do_start();
    checks++;
    if (phase !== 2'd2 || score !== 4'd0 || best !== 4'd3) begin
      failures++; $display("FAIL restart: got phase=%0d score=%0d best=%0d want 2/0/3", phase, score, best);
    end
    btn = 4'b0010;
    repeat (4) begin tick(); if (playerPressed === 1'b1) pulses++; end
    gameOver = 1'b1;
    tick();
    if (playerPressed === 1'b1) pulses++;
    checks++;
    if (phase !== 2'd3) begin failures++; $display("FAIL collide_phase: got %0d want 3", phase); end
    repeat (3) begin tick(); if (playerPressed === 1'b1) pulses++; end
    checks++;
    if (pulses != 0 || playerNum !== 2'd3 || best !== 4'd3) begin
      failures++; $display("FAIL collide_press: got pulses=%0d num=%0d best=%0d want 0/3/3", pulses, playerNum, best);
    end
    gameOver = 1'b0;
    btn = 4'b0000;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    do_start();
    turn_pulse();
    turn_pulse();
    checks++;
    if (score !== 4'd2) begin failures++; $display("FAIL mid_score: got %0d want 2", score); end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (phase !== 2'd0 || score !== 4'd0 || best !== 4'd0) begin
      failures++; $display("FAIL mid_reset_state: got phase=%0d score=%0d best=%0d want 0/0/0", phase, score, best);
    end
    checks++;
    if ({led, simonRst, playerPressed, playerNum} !== 8'h00) begin
      failures++; $display("FAIL mid_reset_outs: got led=%b rst=%b pp=%b pn=%0d want 0", led, simonRst, playerPressed, playerNum);
    end
    tick();
    reset = 1'b1;
    btn = 4'b0100;
    repeat (10) begin tick(); if (playerPressed === 1'b1) pulses++; end
    checks++;
    if (pulses != 0 || phase !== 2'd0) begin
      failures++; $display("FAIL mid_resume: got pulses=%0d phase=%0d want 0/0", pulses, phase);
    end
    btn = 4'b0000;
    repeat (6) tick();
  endtask

  initial begin
    reset        = 1'b0;
    btn          = 4'b0000;
    start        = 1'b0;
    simonTurn    = 1'b0;
    simonNum     = 2'd0;
    simonPressed = 1'b0;
    gameOver     = 1'b0;
    #12;
    test_reset();
    tick();
    reset = 1'b1;
    tick();
    test_start();
    test_single_press();
    test_simultaneous();
    test_glitch();
    test_start_ignored();
    test_simon_turn();
    test_score_over();
    test_over_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simon_sequencer.md
SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 Parameter DEBOUNCE, default 3: consecutive stable clk cycles before a button level change is accepted.
REQ-002 Parameter BLINK, default 30: half-period in clk cycles of the game-over LED blink.
REQ-003 Parameter CLR_CYCLES, default 2: clk cycles simonRst stays asserted per game start.
REQ-004 clk  input  1  system clock, 60 Hz; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 btn  input  4  raw player buttons, asynchronous, active-high; bit i selects colour i.
REQ-007 start  input  1  raw start button, asynchronous, active-high.
REQ-008 simonTurn  input  1  engine turn flag; 1 = engine playing sequence, 0 = player turn.
REQ-009 simonNum  input  2  colour the engine is presenting.
REQ-010 simonPressed  input  1  engine "colour lit" flag.
REQ-011 gameOver  input  1  engine game-over flag.
REQ-012 simonRst  output  1  active-high reset to the engine.
REQ-013 playerNum  output  2  encoded accepted player colour.
REQ-014 playerPressed  output  1  one-cycle strobe qualifying playerNum.
REQ-015 led  output  4  colour lamps, one-hot or all-on/all-off.
REQ-016 score  output  4  rounds cleared in the current game.
REQ-017 best  output  4  highest score since reset.
REQ-018 phase  output  2  controller state: 0 IDLE, 1 CLEAR, 2 PLAY, 3 OVER.

Function
REQ-019 btn and start SHALL each pass through a 2-flop synchroniser and then a per-bit debouncer; the debounced level changes only after DEBOUNCE consecutive equal synchronised samples.
REQ-020 FSM states: IDLE, CLEAR, PLAY, OVER; IDLE->CLEAR on debounced start rising edge; CLEAR->PLAY after CLR_CYCLES cycles; PLAY->OVER when gameOver=1; OVER->CLEAR on debounced start rising edge.
REQ-021 In CLEAR, simonRst SHALL be 1 for exactly CLR_CYCLES cycles, score SHALL be cleared to 0, and no press is forwarded; simonRst is 0 in all other states.
REQ-022 A press is accepted only in PLAY with simonTurn=0 and gameOver=0, on the cycle the debounced btn vector goes from all-zero to non-zero.
REQ-023 On acceptance, playerNum SHALL equal the index of the lowest set debounced bit, and playerPressed SHALL be 1 for exactly that one cycle (latency 0 cycles from the debounced edge).
REQ-024 No further press is accepted until the debounced btn vector returns to all-zero; simultaneous buttons yield one press only.
REQ-025 Buttons held when simonTurn falls SHALL NOT produce a press until released and pressed again.
REQ-026 playerNum SHALL hold its last value between strobes; reset value 0.
REQ-027 LEDs: PLAY and simonTurn=1 -> one-hot(simonNum) when simonPressed=1, else 0; PLAY and simonTurn=0 -> one-hot(playerNum) while the accepted button remains held, else 0; IDLE and CLEAR -> 0.
REQ-028 In OVER, led SHALL toggle between 4'b1111 and 4'b0000 every BLINK cycles, starting at 4'b1111 on the OVER entry cycle.
REQ-029 score SHALL increment on each simonTurn 0->1 transition observed in PLAY with gameOver=0, saturating at 15.
REQ-030 best SHALL update to score on OVER entry when score > best; otherwise best is held.
REQ-031 A start edge while in CLEAR or PLAY SHALL be ignored.
REQ-032 gameOver=1 in the same cycle as a qualifying button edge: OVER is entered and no playerPressed strobe is issued.

Reset
REQ-033 Asynchronous reset SHALL force phase=IDLE, simonRst=0, playerNum=0, playerPressed=0, led=0, score=0, best=0, and clear synchronisers, debouncers and all counters.
REQ-034 Reset asserted mid-game SHALL abort immediately; release SHALL resume in IDLE with no strobe until a new start.

Verification
REQ-035 Start press held 6 cycles from IDLE -> simonRst high exactly 2 cycles, then phase=2, score=0.
REQ-036 PLAY, simonTurn=0, btn=4'b0100 held 10 cycles -> exactly one playerPressed pulse with playerNum=2, 5 cycles after the btn change (2 sync + 3 debounce), led=4'b0100 while held.
REQ-037 btn=4'b1010 simultaneously -> one pulse, playerNum=1; second pulse only after full release and re-press.
REQ-038 btn glitch of 2 cycles -> no pulse; btn pressed while simonTurn=1 -> no pulse, led follows simonNum/simonPressed.
REQ-039 Three simonTurn 0->1 transitions then gameOver=1 -> score=3, best=3, phase=3, led 4'b1111 for 30 cycles then 4'b0000 for 30 cycles.
REQ-040 reset low during PLAY with score=2 -> all outputs zero asynchronously, phase=0, best=0.
